// File: rtl/vid_phy_controller_dru_gearbox.sv
// DRU output gearbox: buffers sparse 40-bit DRU words and drains them as a 20-bit valid/ready stream, low half first.
// Optional macro VID_PHY_DRU_GEARBOX_STATS_EN enables the saturating dropped-word counter on DROP_CNT_OUT.
module vid_phy_controller_dru_gearbox #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK_IN,
  input  logic                     RST_N_IN,
  input  logic                     ACT_IN,
  input  logic [39:0]              DAT_IN,
  input  logic                     DAT_EN_IN,
  output logic [19:0]              DAT_OUT,
  output logic                     DAT_VLD_OUT,
  input  logic                     DAT_RDY_IN,
  output logic [$clog2(DEPTH):0]   LVL_OUT,
  output logic                     OVF_OUT,
  input  logic                     OVF_CLR_IN,
  output logic [15:0]              DROP_CNT_OUT
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [39:0]      mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic [LVL_W-1:0] lvl;
  logic             ph;
  logic             ovf;
  logic             full;
  logic             empty;
  logic             vld;
  logic             half_pop;
  logic             word_pop;
  logic             wr_en;
  logic             drop;
  logic [39:0]      head;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign lvl      = wr_ptr - rd_ptr;
  assign full     = (lvl == LVL_W'(DEPTH));
  assign empty    = (lvl == '0);
  assign vld      = ACT_IN && !empty;
  assign half_pop = vld && DAT_RDY_IN;
  assign word_pop = half_pop && ph;
  assign wr_en    = ACT_IN && DAT_EN_IN && (!full || word_pop);
  assign drop     = ACT_IN && DAT_EN_IN && full && !word_pop;
  assign head     = mem[rd_ptr[AW-1:0]];

  assign DAT_VLD_OUT = vld;
  assign DAT_OUT     = vld ? (ph ? head[39:20] : head[19:0]) : '0;
  assign LVL_OUT     = lvl;
  assign OVF_OUT     = ovf;

  always_ff @(posedge CLK_IN) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= DAT_IN;
    end
  end

  // Inactive DRU flushes the queue but keeps the overflow history.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ph     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (!ACT_IN) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ph     <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (half_pop) begin
          ph <= !ph;
        end
        if (word_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (OVF_CLR_IN) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef VID_PHY_DRU_GEARBOX_STATS_EN
  logic [15:0] drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end else if (OVF_CLR_IN) begin
      drop_cnt <= '0;
    end
  end

  assign DROP_CNT_OUT = drop_cnt;
`else
  assign DROP_CNT_OUT = 16'h0000;
`endif

endmodule

// File: tb/tb_vid_phy_controller_dru_gearbox.sv
// Scoreboard bench for the DRU gearbox: directed writes push expected half-words, a negedge monitor pops and compares.
module tb_vid_phy_controller_dru_gearbox;

`ifdef VID_PHY_DRU_GEARBOX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        act = 1'b0;
  logic [39:0] dat = '0;
  logic        en = 1'b0;
  logic        rdy = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [19:0] dat_out;
  logic        dat_vld;
  logic [2:0]  lvl;
  logic        ovf;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];
  logic        hold = 1'b0;
  logic [19:0] hold_val = '0;

  vid_phy_controller_dru_gearbox #(.DEPTH(4)) dut (
    .CLK_IN(clk), .RST_N_IN(rst_n), .ACT_IN(act), .DAT_IN(dat), .DAT_EN_IN(en),
    .DAT_OUT(dat_out), .DAT_VLD_OUT(dat_vld), .DAT_RDY_IN(rdy), .LVL_OUT(lvl),
    .OVF_OUT(ovf), .OVF_CLR_IN(ovf_clr), .DROP_CNT_OUT(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: compares accepted half-words against the scoreboard and checks hold stability.
  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold && dat_vld) begin
        checks++;
        if (dat_out !== hold_val) begin
          failures++;
          $display("FAIL stall_stable: got %h required %h", dat_out, hold_val);
        end
      end
      if (dat_vld && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got %h required no output", dat_out);
        end else begin
          e = exp_q.pop_front();
          if (dat_out !== e) begin
            failures++;
            $display("FAIL out_data: got %h required %h", dat_out, e);
          end
        end
      end
      hold = dat_vld && !rdy;
      hold_val = dat_out;
    end
  end

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] mkw(input logic [7:0] tag, input logic [7:0] i);
    return {tag, 4'h1, i, tag, 4'h0, i};
  endfunction

  task automatic wr(input logic [39:0] d, input bit push);
    dat = d;
    en = 1'b1;
    if (push) begin
      exp_q.push_back(d[19:0]);
      exp_q.push_back(d[39:20]);
    end
    tick();
    en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    rdy = 1'b1;
    en = 1'b0;
    while (exp_q.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending required 0", name, exp_q.size());
    end
    tick();
    chk({name, "_lvl"}, 40'(lvl), 40'd0);
    chk({name, "_vld"}, 40'(dat_vld), 40'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_dat", 40'(dat_out), 40'd0);
    chk("rst_vld", 40'(dat_vld), 40'd0);
    chk("rst_lvl", 40'(lvl), 40'd0);
    chk("rst_ovf", 40'(ovf), 40'd0);
    chk("rst_drop", 40'(drop_cnt), 40'd0);
    #10;
    rst_n = 1'b1;
    act = 1'b1;
    rdy = 1'b1;
    tick();

    // Single word
    wr(40'h12345_6789A, 1'b1);
    chk("sw_lvl0", 40'(lvl), 40'd1);
    chk("sw_lo", 40'(dat_out), 40'h6789A);
    tick();
    chk("sw_lvl1", 40'(lvl), 40'd1);
    chk("sw_hi", 40'(dat_out), 40'h12345);
    tick();
    chk("sw_lvl2", 40'(lvl), 40'd0);
    chk("sw_vld", 40'(dat_vld), 40'd0);

    // Overflow: A4 is dropped
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) wr(mkw(8'hA0, 8'(i)), i < 4);
    chk("ovf_lvl", 40'(lvl), 40'd4);
    chk("ovf_flag", 40'(ovf), 40'd1);
    chk("ovf_drop", 40'(drop_cnt), STATS ? 40'd1 : 40'd0);
    drain("ovf");

    // Full with simultaneous word pop
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr(mkw(8'hC0, 8'(i)), 1'b1);
    chk("fp_full", 40'(lvl), 40'd4);
    rdy = 1'b1;
    tick();
    chk("fp_ph1_lvl", 40'(lvl), 40'd4);
    wr(mkw(8'hB0, 8'h0B), 1'b1);
    chk("fp_lvl", 40'(lvl), 40'd4);
    chk("fp_drop", 40'(drop_cnt), STATS ? 40'd1 : 40'd0);
    chk("fp_ovf", 40'(ovf), 40'd1);
    drain("fp");

    // Backpressure toggling every cycle
    rdy = 1'b0;
    for (int i = 0; i < 40 && (i < 3 || exp_q.size() != 0); i++) begin
      rdy = i[0];
      if (i < 3) begin
        dat = mkw(8'hD0, 8'(i));
        en = 1'b1;
        exp_q.push_back(dat[19:0]);
        exp_q.push_back(dat[39:20]);
      end else begin
        en = 1'b0;
      end
      tick();
    end
    en = 1'b0;
    chk("bp_pending", 40'(exp_q.size()), 40'd0);
    chk("bp_lvl", 40'(lvl), 40'd0);

    // Flush keeps overflow history
    rdy = 1'b0;
    wr(mkw(8'hF0, 8'h0), 1'b0);
    wr(mkw(8'hF0, 8'h1), 1'b0);
    chk("fl_lvl2", 40'(lvl), 40'd2);
    act = 1'b0;
    #1;
    chk("fl_vld_low", 40'(dat_vld), 40'd0);
    tick();
    act = 1'b1;
    #1;
    chk("fl_lvl", 40'(lvl), 40'd0);
    chk("fl_vld", 40'(dat_vld), 40'd0);
    chk("fl_ovf", 40'(ovf), 40'd1);
    chk("fl_drop", 40'(drop_cnt), STATS ? 40'd1 : 40'd0);

    // Overflow clear
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", 40'(ovf), 40'd0);
    chk("clr_drop", 40'(drop_cnt), 40'd0);

    // Asynchronous reset mid-drain
    rdy = 1'b0;
    wr(mkw(8'hE0, 8'h0), 1'b1);
    wr(mkw(8'hE0, 8'h1), 1'b1);
    rdy = 1'b1;
    tick();
    chk("ar_pre_vld", 40'(dat_vld), 40'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dat", 40'(dat_out), 40'd0);
    chk("ar_vld", 40'(dat_vld), 40'd0);
    chk("ar_lvl", 40'(lvl), 40'd0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_ovf", 40'(ovf), 40'd0);
    chk("ar_drop", 40'(drop_cnt), 40'd0);
    chk("ar_lvl_after", 40'(lvl), 40'd0);

    // Drop-counter saturation
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr(mkw(8'h50, 8'(i)), 1'b0);
    dat = mkw(8'h5F, 8'hFF);
    en = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (i == 99) chk("sat_drop100", 40'(drop_cnt), STATS ? 40'd100 : 40'd0);
    end
    en = 1'b0;
    chk("sat_drop", 40'(drop_cnt), STATS ? 40'hFFFF : 40'd0);
    chk("sat_ovf", 40'(ovf), 40'd1);
    chk("sat_lvl", 40'(lvl), 40'd4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sat_clr_drop", 40'(drop_cnt), 40'd0);
    chk("sat_clr_ovf", 40'(ovf), 40'd0);
    act = 1'b0;
    tick();
    act = 1'b1;
    #1;
    chk("sat_flush_lvl", 40'(lvl), 40'd0);

    chk("final_pending", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vid_phy_controller_dru_gearbox.md
# vid_phy_controller_dru_gearbox

DRU output gearbox. Accepts the sparse 40-bit words and data-enable strobes produced by the DRU stage and buffers them in a small FIFO. It drains them as a 20-bit valid/ready stream, low half first, to the downstream symbol-alignment/decoder logic. It absorbs the DRU's bursty enable pattern, reports overflow, and flushes whenever the DRU is inactive.

## Interface
- DEPTH, 4: FIFO depth in 40-bit words; power of 2, ≥2.
- CLK_IN  input  1  link clock, same clock as the DRU.
- RST_N_IN  input  1  reset; asynchronous, active-low.
- ACT_IN  input  1  DRU active; low flushes the FIFO and blocks writes.
- DAT_IN  input  40  DRU data word.
- DAT_EN_IN  input  1  DRU data enable; one word per cycle when high.
- DAT_OUT  output  20  output half-word.
- DAT_VLD_OUT  output  1  DAT_OUT valid.
- DAT_RDY_IN  input  1  downstream ready.
- LVL_OUT  output  $clog2(DEPTH)+1  number of stored words, including the partially drained head.
- OVF_OUT  output  1  sticky overflow flag.
- OVF_CLR_IN  input  1  clears OVF_OUT; synchronous.
- DROP_CNT_OUT  output  16  count of dropped words (see Configuration).

## Operation
- Storage: DEPTH×40 memory, write pointer and read pointer each $clog2(DEPTH)+1 bits, and a half-select bit ph.
  - ph=0 selects the head's bits [19:0]; ph=1 selects bits [39:20].
- Full: LVL_OUT==DEPTH. Empty: LVL_OUT==0.
- Half pop: occurs when DAT_VLD_OUT && DAT_RDY_IN.
  - With ph=0, ph becomes 1.
  - With ph=1, ph becomes 0 and the read pointer increments (word pop).
- Write: occurs when ACT_IN && DAT_EN_IN && (!full || word pop in the same cycle); DAT_IN is stored at the write pointer.
- Drop: occurs when ACT_IN && DAT_EN_IN && full && no word pop. The word is discarded, OVF_OUT is set, and DROP_CNT_OUT increments.
- LVL_OUT: +1 on a write without a word pop; −1 on a word pop without a write; unchanged on both or neither.
- DAT_VLD_OUT = !empty. DAT_OUT is read combinationally from the head entry through the ph mux, and is 0 when empty.
- Flush: ACT_IN low for a cycle clears pointers, ph and LVL_OUT at the next edge. OVF_OUT and DROP_CNT_OUT are retained. While ACT_IN is low, DAT_VLD_OUT=0.
- OVF_OUT: if OVF_CLR_IN and a drop occur in the same cycle, set wins.
- Pointer wrap-around is natural modulo 2·DEPTH; the MSB distinguishes full from empty.

## Timing
- Reset values: DAT_OUT=0, DAT_VLD_OUT=0, LVL_OUT=0, OVF_OUT=0, DROP_CNT_OUT=0, ph=0, both pointers 0.
- Latency: a word written at edge N gives DAT_VLD_OUT=1 and its low half on DAT_OUT after edge N. Its high half follows after the first accepted half pop.
- Sustained throughput: one half-word per cycle. The input may therefore average at most one word every 2 cycles without overflow.
- Handshake:
  - DAT_VLD_OUT never drops without an accepted pop, except on flush or reset.
  - DAT_OUT is stable while DAT_VLD_OUT && !DAT_RDY_IN.
- Full with a word pop in the same cycle: the write is accepted, no drop occurs, and LVL_OUT stays DEPTH.
- Asynchronous reset mid-stream clears all state immediately. DAT_VLD_OUT deasserts without waiting for a clock edge.

## Configuration
- Macro VID_PHY_DRU_GEARBOX_STATS_EN.
  - Defined: DROP_CNT_OUT is a 16-bit counter, saturating at 0xFFFF, cleared by reset and by OVF_CLR_IN. Increment wins over OVF_CLR_IN in the same cycle.
  - Undefined: the counter logic is not compiled and DROP_CNT_OUT is tied to 0. OVF_OUT behaviour is unchanged.

## Test plan
- Single word: ACT_IN=1, RDY=1, write DAT_IN=40'h12345_6789A -> DAT_OUT=20'h6789A, then 20'h12345 on consecutive cycles; LVL_OUT goes 1 -> 1 -> 0.
- Overflow: RDY=0, DEPTH=4, write 5 words A0..A4 on consecutive cycles -> LVL_OUT=4, OVF_OUT=1, DROP_CNT_OUT=1 (stats build); draining returns only A0..A3, in order.
- Full with simultaneous pop: FIFO full with ph=1 and RDY=1, write B on the same cycle -> no drop, LVL_OUT stays 4, B is later read after the preceding three words.
- Backpressure: toggle RDY 1/0 every cycle over 3 words -> each half is held stable while RDY=0; the output sequence is exactly low/high of each word, with no duplicates.
- Flush and reset: after 2 words are buffered, drive ACT_IN=0 for one cycle -> LVL_OUT=0 and DAT_VLD_OUT=0, OVF_OUT retained. Assert RST_N_IN=0 asynchronously mid-drain -> all outputs are 0 before the next edge.
- Stats saturation (macro defined): force 65 540 drops -> DROP_CNT_OUT=16'hFFFF. Assert OVF_CLR_IN with no drop -> DROP_CNT_OUT=0 and OVF_OUT=0. With the macro undefined, the same stimulus gives DROP_CNT_OUT=0 throughout.
